mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data width; ADDR_W, default 9, word address width; MAX_D_STREAK, default 2, consecutive data grants allowed while fetch waits; TIMEOUT, default 15, busy cycles before abort.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 if_req  in  1  fetch requester request; held with if_addr until if_ack.
REQ-005 if_addr  in  ADDR_W  fetch address.
REQ-006 if_ack  out  1  one-cycle completion pulse to fetch.
REQ-007 if_rdata  out  DATA_W  fetched word, valid while if_ack=1.
REQ-008 d_req, d_we  in  1 each  data request; write enable; held with d_addr and d_wdata until d_ack.
REQ-009 d_addr  in  ADDR_W; d_wdata  in  DATA_W  data address; store data.
REQ-010 d_ack  out  1; d_rdata  out  DATA_W  one-cycle completion pulse; load data, valid with d_ack.
REQ-011 err  out  1  high with the ack pulse when the transaction timed out.
REQ-012 if_stall, d_stall  out  1 each  pipeline stall = req & ~ack per requester, combinational.
REQ-013 mem_req, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  registered single-port memory request.
REQ-014 mem_ack  in  1; mem_rdata  in  DATA_W  memory completion; rdata valid when mem_ack=1.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, RESP.
REQ-016 IDLE: no request -> IDLE; a request -> BUSY, latching winner id, address, we and wdata (we=0 for fetch).
REQ-017 Arbitration: data wins over fetch unless streak counter = MAX_D_STREAK and if_req=1, in which case fetch wins.
REQ-018 Streak counter SHALL increment on a data grant while if_req=1, clear on any fetch grant, clear on a data grant with if_req=0, and saturate at MAX_D_STREAK.
REQ-019 BUSY: mem_req=1 with latched fields stable; mem_ack=1 -> RESP, capturing mem_rdata into the winner's rdata register, err=0.
REQ-020 BUSY timeout: the TIMEOUT-th consecutive BUSY cycle without mem_ack -> RESP with rdata=0 and err=1; mem_ack in that same cycle takes precedence (normal completion).
REQ-021 RESP: exactly one of if_ack/d_ack high for one cycle per the latched id; mem_req=0; next state IDLE unconditionally.
REQ-022 Minimum request-to-ack latency SHALL be 3 cycles (IDLE grant, BUSY with same-cycle mem_ack, RESP).
REQ-023 mem_ack outside BUSY SHALL be ignored.
REQ-024 rdata registers SHALL hold their last value between acks; stores leave d_rdata unchanged.
REQ-025 Simultaneous if_req and d_req with streak < MAX_D_STREAK -> data granted, fetch stalls.

Reset
REQ-026 Asserting reset in any state SHALL immediately force IDLE, clear the streak and timeout counters, and drive all outputs to 0 (mem_req, mem_we, mem_addr, mem_wdata, acks, err, rdata).
REQ-027 A transaction in flight when reset asserts SHALL be dropped without an ack; a late mem_ack after release is ignored per REQ-023.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum, the requester-id enum (REQ_IF, REQ_D) and the default parameter constants.
REQ-029 Sub-module mem_arb_timeout SHALL implement the BUSY cycle counter (clear, enable, expired output).
REQ-030 Target size: 120-400 lines of RTL.

Verification
REQ-031 Fetch-only: if_req=1, if_addr=0x010, mem_ack one cycle after mem_req with rdata 0x00A00093 -> if_ack at cycle 4, if_rdata=0x00A00093, err=0.
REQ-032 Store: d_req=1, d_we=1, d_addr=0x1FF, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x1FF, mem_wdata=0xDEADBEEF while BUSY; d_ack once; d_rdata unchanged.
REQ-033 Contention: if_req and d_req held continuously, MAX_D_STREAK=2 -> grant order D, D, IF, D, D, IF; each ack is a single pulse.
REQ-034 Timeout: d_req=1, mem_ack never asserted, TIMEOUT=15 -> d_ack with err=1 and d_rdata=0 after the 15th BUSY cycle; state returns to IDLE.
REQ-035 Reset mid-BUSY: drop reset low for 1 cycle while mem_req=1 -> outputs 0 immediately, no ack, a subsequent mem_ack pulse produces nothing, a new fetch completes normally.
REQ-036 Stall: d_req raised while fetch is BUSY -> d_stall=1 until d_ack cycle, if_stall=0 in if_ack cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the fetch/data memory arbiter.
package mem_arb_pkg;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 9;
  localparam int DEF_MAX_D_STREAK = 2;
  localparam int DEF_TIMEOUT      = 15;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  typedef enum logic {REQ_IF, REQ_D} req_id_e;
endpackage

// File: rtl/mem_arb_timeout.sv
// Counts consecutive BUSY cycles; expired marks the TIMEOUT-th one.
module mem_arb_timeout #(
  parameter int TIMEOUT = 15
)(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of earlier BUSY cycles, so the current one is cnt+1
  assign expired = en & (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expired)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, data) arbiter onto one single-port memory with
// data priority, bounded data streak and a BUSY timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int TIMEOUT      = DEF_TIMEOUT
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              if_stall,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);

  arb_state_e        state, state_n;
  req_id_e           id_q;
  logic [SW-1:0]     streak;
  logic              streak_max;
  logic              grant_d, grant_if, any_req;
  logic              expired, done;
  logic              err_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  assign any_req    = if_req | d_req;
  assign streak_max = (streak == SW'(MAX_D_STREAK));
  // data has priority until it has starved fetch for MAX_D_STREAK grants
  assign grant_d    = d_req & ~(streak_max & if_req);
  assign grant_if   = if_req & ~grant_d;
  assign done       = (state == BUSY) & (mem_ack | expired);

  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (state != BUSY),
    .en      (state == BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = BUSY;
      BUSY:    if (mem_ack || expired) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q       <= REQ_IF;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        id_q      <= grant_d ? REQ_D : REQ_IF;
        mem_req   <= 1'b1;
        mem_we    <= grant_d & d_we;
        mem_addr  <= grant_d ? d_addr : if_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
      end
      if (done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        // a same-cycle mem_ack beats the timeout
        err_q   <= ~mem_ack;
        if (id_q == REQ_IF)
          if_rdata_q <= mem_ack ? mem_rdata : '0;
        else if (!mem_we)
          d_rdata_q  <= mem_ack ? mem_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (grant_if)
        streak <= '0;
      else if (grant_d) begin
        if (!if_req)          streak <= '0;
        else if (!streak_max) streak <= streak + 1'b1;
      end
    end
  end

  assign if_ack   = (state == RESP) & (id_q == REQ_IF);
  assign d_ack    = (state == RESP) & (id_q == REQ_D);
  assign err      = (state == RESP) & err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// contention, stall and reset-in-flight sequences.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [8:0]  if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [8:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err, if_stall, d_stall;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  int          resp_delay = 255;
  int          bc = 0;
  logic [31:0] resp_data = '0;
  bit          inject = 1'b0;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[7];

  mem_arbiter #(.DATA_W(32), .ADDR_W(9), .MAX_D_STREAK(2), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .if_stall(if_stall), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory model: acks in the (resp_delay+1)-th BUSY cycle
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack   = (bc == resp_delay);
      mem_rdata = resp_data;
      bc++;
    end else begin
      mem_ack = inject;
      bc      = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // starts on a negedge (cycle 1); the negedge after posedge k observes cycle k+1
  task automatic run_vec(input vec_t v, input int idx);
    bit got = 0, seen = 0, stall_ok = 1;
    int lat = 0;
    resp_delay = v.delay;
    resp_data  = v.mrdata;
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    for (int c = 2; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (mem_req && !seen) begin
        seen = 1;
        chk($sformatf("v%0d_mem_addr", idx), 64'(mem_addr), 64'(v.addr));
        chk($sformatf("v%0d_mem_we", idx), 64'(mem_we), 64'(v.is_d & v.we));
        if (v.is_d && v.we) chk($sformatf("v%0d_mem_wdata", idx), 64'(mem_wdata), 64'(v.wdata));
      end
      if (v.is_d ? d_ack : if_ack) begin
        got = 1;
        lat = c;
        chk($sformatf("v%0d_err", idx), 64'(err), 64'(v.exp_err));
        chk($sformatf("v%0d_if_rdata", idx), 64'(if_rdata), 64'(v.exp_if_rdata));
        chk($sformatf("v%0d_d_rdata", idx), 64'(d_rdata), 64'(v.exp_d_rdata));
        chk($sformatf("v%0d_other_ack", idx), 64'(v.is_d ? if_ack : d_ack), 64'd0);
        chk($sformatf("v%0d_stall_at_ack", idx), 64'(v.is_d ? d_stall : if_stall), 64'd0);
        if_req = 0;
        d_req  = 0;
      end else if ((v.is_d ? d_stall : if_stall) !== 1'b1) begin
        stall_ok = 0;
      end
    end
    chk($sformatf("v%0d_ack_seen", idx), 64'(got), 64'd1);
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d_stall_wait", idx), 64'(stall_ok), 64'd1);
    @(negedge clk);
    chk($sformatf("v%0d_single_pulse", idx), 64'({if_ack, d_ack, mem_req}), 64'd0);
  endtask

  logic [5:0] order;
  int         n;
  bit         pulse_ok, prev, got_if, got_d, stall_ok, stray_ok;

  initial begin
    //               is_d we addr    wdata         mrdata        dly  lat err if_rdata      d_rdata
    vecs[0] = '{1'b0, 1'b0, 9'h010, 32'h0,        32'h00A00093, 1,   4,  1'b0, 32'h00A00093, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 9'h055, 32'h0,        32'h12345678, 2,   5,  1'b0, 32'h00A00093, 32'h12345678};
    vecs[2] = '{1'b1, 1'b1, 9'h1FF, 32'hDEADBEEF, 32'hFFFFFFFF, 0,   3,  1'b0, 32'h00A00093, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 9'h0AA, 32'h0,        32'h55555555, 255, 17, 1'b1, 32'h00A00093, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 9'h120, 32'h0,        32'hCAFEF00D, 14,  17, 1'b0, 32'hCAFEF00D, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 9'h000, 32'h0,        32'h00000013, 0,   3,  1'b0, 32'h00000013, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 9'h1A0, 32'h0,        32'h0BADF00D, 1,   4,  1'b0, 32'h0BADF00D, 32'h0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, err}), 64'd0);
    chk("reset_rdata", {if_rdata, d_rdata}, 64'd0);
    reset = 1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // both requesters held: D, D, IF, D, D, IF
    if_addr = 9'h100; d_addr = 9'h020; d_we = 0;
    resp_delay = 0; resp_data = 32'h5A5A0000;
    if_req = 1; d_req = 1;
    n = 0; order = '0; pulse_ok = 1; prev = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      @(negedge clk);
      if (if_ack && d_ack) pulse_ok = 0;
      if ((if_ack || d_ack) && prev) pulse_ok = 0;
      prev = if_ack | d_ack;
      if (d_ack) begin order[n] = 1'b1; n++; end
      else if (if_ack) begin order[n] = 1'b0; n++; end
    end
    if_req = 0; d_req = 0;
    chk("contention_count", 64'(n), 64'd6);
    chk("contention_order", 64'(order), 64'(6'b011011));
    chk("contention_pulses", 64'(pulse_ok), 64'd1);
    @(negedge clk);

    // data request arrives while fetch is in BUSY
    resp_delay = 3; resp_data = 32'h0000ABCD;
    if_addr = 9'h044; if_req = 1;
    @(negedge clk);
    chk("stall_fetch_busy", 64'(mem_req), 64'd1);
    d_we = 0; d_addr = 9'h066; d_req = 1;
    #1;
    chk("stall_d_raise", 64'(d_stall), 64'd1);
    got_if = 0; got_d = 0; stall_ok = 1;
    for (int c = 0; c < 60 && !got_d; c++) begin
      @(negedge clk);
      if (if_ack) begin
        got_if = 1;
        chk("stall_if_at_if_ack", 64'(if_stall), 64'd0);
        chk("stall_d_at_if_ack", 64'(d_stall), 64'd1);
        if_req = 0;
      end
      if (d_ack) begin
        got_d = 1;
        chk("stall_d_at_d_ack", 64'(d_stall), 64'd0);
        d_req = 0;
      end else if (d_req && d_stall !== 1'b1) begin
        stall_ok = 0;
      end
    end
    chk("stall_if_acked", 64'(got_if), 64'd1);
    chk("stall_d_acked", 64'(got_d), 64'd1);
    chk("stall_d_held", 64'(stall_ok), 64'd1);
    @(negedge clk);

    // reset while BUSY, then a stray mem_ack, then a normal fetch
    resp_delay = 255;
    if_addr = 9'h033; if_req = 1;
    @(negedge clk);
    chk("rst_busy", 64'(mem_req), 64'd1);
    reset = 0; if_req = 0;
    #1;
    chk("rst_async_outputs", 64'({mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, err}), 64'd0);
    chk("rst_async_rdata", {if_rdata, d_rdata}, 64'd0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1 inject = 1;
    @(negedge clk);
    #1 inject = 0;
    stray_ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (if_ack || d_ack || mem_req || err) stray_ok = 0;
    end
    chk("rst_stray_ack_ignored", 64'(stray_ok), 64'd1);
    chk("rst_rdata_held", {if_rdata, d_rdata}, 64'd0);
    run_vec(vecs[6], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
